// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and field offsets for the bus-watch debug probe
//
// Purpose : capture-state encodings and the bit layout of the 64-bit debug record
//           that feeds the text overlay.
// Contents: state_t (ST_ARMED/ST_RUN/ST_HOLD), DBG_*_LSB field offsets.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'b00,
        ST_RUN   = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    // o_debug = {hit_count[15:0], last_addr[15:0], d3, d2, d1, d0}
    localparam int DBG_CNT_LSB  = 48;
    localparam int DBG_ADDR_LSB = 32;
    localparam int DBG_DATA_LSB = 0;

endpackage

// File: rtl/debug_sync2.sv
// rtl/debug_sync2.sv - two-flop level synchroniser with async active-low reset
//
// Purpose : bring an asynchronous level (freeze button / OSD) into the clk domain.
// Ports   : clk        in  1  destination clock
//           i_reset_n  in  1  asynchronous active-low reset
//           i_d        in  1  asynchronous level
//           o_q        out 1  synchronised level, two clocks of latency
module debug_sync2 (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/debug_bus_probe.sv
// rtl/debug_bus_probe.sv - CPU write watcher publishing a per-frame debug record
//
// Purpose : counts CPU write strokes matching an address/mask, keeps the last
//           address and last four data bytes, and publishes the record to the
//           overlay once per frame at vblank start. Continuous or one-shot
//           capture, with clear and freeze.
// Ports   : clk           in  1   system clock
//           i_reset_n     in  1   asynchronous active-low reset
//           i_addr        in  16  CPU address bus
//           i_data        in  8   CPU write data
//           i_wr          in  1   CPU write strobe (level, may span several clk)
//           i_match_addr  in  16  watch address
//           i_match_mask  in  16  1 = bit compared, 0 = don't care
//           i_oneshot     in  1   1 = one-shot capture, 0 = continuous
//           i_clear       in  1   synchronous clear pulse
//           i_freeze      in  1   asynchronous level, 1 = suppress publishing
//           i_v           in  12  current video line
//           o_debug       out 64  published {hit_count, last_addr, d3..d0}
//           o_state       out 2   00 ARMED, 01 RUN, 10 HOLD
//           o_update      out 1   one-clk pulse when o_debug is refreshed
module debug_bus_probe
    import debug_pkg::*;
#(
    parameter logic [11:0] VBLANK_LINE   = 12'd224,
    parameter int          ONESHOT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_wr,
    input  logic [15:0] i_match_addr,
    input  logic [15:0] i_match_mask,
    input  logic        i_oneshot,
    input  logic        i_clear,
    input  logic        i_freeze,
    input  logic [11:0] i_v,
    output logic [63:0] o_debug,
    output logic [1:0]  o_state,
    output logic        o_update
);

    localparam logic [3:0] DEPTH = 4'(ONESHOT_DEPTH);

    // ------------------------------------------------------------------
    // Strobe edge detect and address comparator
    // ------------------------------------------------------------------
    logic r_wr_d;
    logic w_match;
    logic w_hit;

    assign w_match = (((i_addr ^ i_match_addr) & i_match_mask) == 16'h0000);
    assign w_hit   = i_wr & ~r_wr_d & w_match;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_since;
    logic [3:0] w_since_inc;
    logic [3:0] w_since_nxt;
    logic       w_record;

    // since never passes DEPTH, so enabling one-shot late still terminates
    // on the very next hit.
    assign w_since_inc = (r_since >= DEPTH) ? DEPTH : r_since + 4'd1;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_hit) begin
                        w_state_nxt = (i_oneshot && DEPTH == 4'd1) ? ST_HOLD : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hit && i_oneshot && w_since_inc == DEPTH) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: w_state_nxt = ST_HOLD;
                default: w_state_nxt = ST_ARMED;
            endcase
        end
    end

    always_comb begin
        w_record    = 1'b0;
        w_since_nxt = r_since;
        if (i_clear) begin
            w_since_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_hit) begin
                        w_record    = 1'b1;
                        w_since_nxt = 4'd1;
                    end
                end
                ST_RUN: begin
                    if (w_hit) begin
                        w_record    = 1'b1;
                        w_since_nxt = w_since_inc;
                    end
                end
                default: begin
                    w_record    = 1'b0;
                    w_since_nxt = r_since;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow record
    // ------------------------------------------------------------------
    logic [15:0] r_cnt;
    logic [15:0] r_last_addr;
    logic [31:0] r_hist;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_d      <= 1'b0;
            r_since     <= 4'd0;
            r_cnt       <= 16'h0000;
            r_last_addr <= 16'h0000;
            r_hist      <= 32'h0000_0000;
        end else begin
            r_wr_d  <= i_wr;
            r_since <= w_since_nxt;
            if (i_clear) begin
                r_cnt       <= 16'h0000;
                r_last_addr <= 16'h0000;
                r_hist      <= 32'h0000_0000;
            end else if (w_record) begin
                r_cnt       <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                r_last_addr <= i_addr;
                r_hist      <= {r_hist[23:0], i_data};
            end
        end
    end

    // ------------------------------------------------------------------
    // Freeze synchroniser and per-frame publish
    // ------------------------------------------------------------------
    logic        w_freeze_s;
    logic [11:0] r_v_d;
    logic        w_vb;
    logic [63:0] r_debug;
    logic        r_update;

    debug_sync2 u_freeze_sync (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_freeze),
        .o_q       (w_freeze_s)
    );

    assign w_vb = (i_v == VBLANK_LINE) && (r_v_d != VBLANK_LINE);

    // Publish samples the shadow as it stands before this edge, so a hit or
    // clear landing in the publish cycle does not affect this frame's record.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v_d    <= 12'h000;
            r_debug  <= 64'h0;
            r_update <= 1'b0;
        end else begin
            r_v_d    <= i_v;
            r_update <= w_vb & ~w_freeze_s;
            if (w_vb && !w_freeze_s) begin
                r_debug[DBG_CNT_LSB  +: 16] <= r_cnt;
                r_debug[DBG_ADDR_LSB +: 16] <= r_last_addr;
                r_debug[DBG_DATA_LSB +: 32] <= r_hist;
            end
        end
    end

    assign o_debug  = r_debug;
    assign o_update = r_update;
    assign o_state  = r_state;

endmodule
